// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the
// data stage: one access at a time, latched request, timeout-protected handshake.
module mem_port_arbiter #(
   parameter int             AW       = 32,
   parameter int             DW       = 32,
   parameter int             TIMEOUT  = 64,
   parameter logic [DW-1:0]  ERR_DATA = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_valid,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic [2:0]    d_size,
   output logic [DW-1:0] d_rdata,
   output logic          d_valid,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [2:0]    mem_size,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          stallF,
   output logic          stallM,
   output logic          err_timeout
);

   localparam int            CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, D_ACC = 2'd1, I_ACC = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [2:0]      size_q, size_d;
   logic            we_q, we_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            acc_s, tmo_s, done_s;
   logic [DW-1:0]   rdata_s;

   // A wait that reaches its last allowed cycle without mem_ready is forced to finish.
   assign acc_s   = (state_q != IDLE);
   assign tmo_s   = acc_s & ~mem_ready & (cnt_q == CNT_LAST);
   assign done_s  = acc_s & (mem_ready | tmo_s);
   assign rdata_s = tmo_s ? ERR_DATA : mem_rdata;

   assign if_valid    = (state_q == I_ACC) & done_s;
   assign d_valid     = (state_q == D_ACC) & done_s;
   assign if_rdata    = (state_q == I_ACC) ? rdata_s : {DW{1'b0}};
   assign d_rdata     = (state_q == D_ACC) ? rdata_s : {DW{1'b0}};
   assign mem_en      = acc_s;
   assign mem_we      = we_q & (state_q == D_ACC);
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_size    = size_q;
   assign stallF      = if_req & ~if_valid;
   assign stallM      = d_req & ~d_valid;
   assign err_timeout = err_q;

   // Grant selection, request latching and wait counting.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      we_d    = we_q;
      cnt_d   = cnt_q;
      err_d   = err_q | tmo_s;
      case (state_q)
         IDLE: begin
            cnt_d = {CW{1'b0}};
            if (d_req) begin
               state_d = D_ACC;
               addr_d  = d_addr;
               wdata_d = d_wdata;
               size_d  = d_size;
               we_d    = d_we;
            end else if (if_req) begin
               state_d = I_ACC;
               addr_d  = if_addr;
               size_d  = 3'b010;
               we_d    = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         D_ACC: begin
            if (done_s) begin
               cnt_d = {CW{1'b0}};
               // The finishing data requester still holds d_req; fetch goes next.
               if (if_req) begin
                  state_d = I_ACC;
                  addr_d  = if_addr;
                  size_d  = 3'b010;
                  we_d    = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         I_ACC: begin
            if (done_s) begin
               cnt_d = {CW{1'b0}};
               if (d_req) begin
                  state_d = D_ACC;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
                  size_d  = d_size;
                  we_d    = d_we;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CW{1'b0}};
         end
      endcase
   end

   // State and latched-request registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= {AW{1'b0}};
         wdata_q <= {DW{1'b0}};
         size_q  <= 3'b000;
         we_q    <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected completions are queued as each
// access is set up and matched against the valid strobes as they appear.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we, mem_ready;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [2:0]  d_size;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_valid, d_valid, mem_en, mem_we, stallF, stallM, err_timeout;
   logic [2:0]  mem_size;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stallF(stallF), .stallM(stallM), .err_timeout(err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push(input logic is_d, input logic [31:0] data);
      exp_t e;
      e.is_d = is_d;
      e.data = data;
      sb.push_back(e);
   endtask

   // Every completion strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (if_valid || d_valid) begin
         chk("both_valid", {31'd0, if_valid & d_valid}, 32'd0);
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("valid_src", {31'd0, d_valid}, {31'd0, mon_e.is_d});
            chk("rdata", d_valid ? d_rdata : if_rdata, mon_e.data);
         end
      end
   end

   initial begin
      reset = 1'b1; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
      d_addr = 32'd0; d_wdata = 32'd0; d_size = 3'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
      nxt(); nxt();
      smp();
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_err", {31'd0, err_timeout}, 32'd0);
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_d_valid", {31'd0, d_valid}, 32'd0);

      // Fetch with mem_ready on the second access cycle, address changing mid-access.
      nxt(); reset = 1'b0; if_req = 1'b1; if_addr = 32'h100;
      smp();
      chk("f_idle_en", {31'd0, mem_en}, 32'd0);
      chk("f_idle_stallF", {31'd0, stallF}, 32'd1);
      nxt(); push(1'b0, 32'hDEAD_BEEF);
      smp();
      chk("f_c1_en", {31'd0, mem_en}, 32'd1);
      chk("f_c1_addr", mem_addr, 32'h100);
      chk("f_c1_we", {31'd0, mem_we}, 32'd0);
      chk("f_c1_valid", {31'd0, if_valid}, 32'd0);
      chk("f_c1_stallF", {31'd0, stallF}, 32'd1);
      nxt(); mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; if_addr = 32'h104;
      smp();
      chk("f_c2_en", {31'd0, mem_en}, 32'd1);
      chk("f_c2_addr", mem_addr, 32'h100);
      chk("f_c2_valid", {31'd0, if_valid}, 32'd1);
      chk("f_c2_stallF", {31'd0, stallF}, 32'd0);
      nxt(); if_req = 1'b0; mem_ready = 1'b0;
      smp();
      chk("f_done_en", {31'd0, mem_en}, 32'd0);
      chk("f_done_rdata", if_rdata, 32'd0);

      // Simultaneous requests: data first, fetch directly after.
      nxt(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h55; d_size = 3'b000;
      if_req = 1'b1; if_addr = 32'h300;
      smp();
      chk("p_idle_stallM", {31'd0, stallM}, 32'd1);
      nxt(); mem_ready = 1'b1; mem_rdata = 32'h1111_1111; push(1'b1, 32'h1111_1111);
      smp();
      chk("p_d_we", {31'd0, mem_we}, 32'd1);
      chk("p_d_size", {29'd0, mem_size}, 32'd0);
      chk("p_d_addr", mem_addr, 32'h2000);
      chk("p_d_wdata", mem_wdata, 32'h55);
      chk("p_d_valid", {31'd0, d_valid}, 32'd1);
      nxt(); d_req = 1'b0; mem_rdata = 32'h2222_2222; push(1'b0, 32'h2222_2222);
      smp();
      chk("p_i_en", {31'd0, mem_en}, 32'd1);
      chk("p_i_we", {31'd0, mem_we}, 32'd0);
      chk("p_i_addr", mem_addr, 32'h300);
      chk("p_i_size", {29'd0, mem_size}, 32'd2);
      chk("p_i_valid", {31'd0, if_valid}, 32'd1);
      nxt(); if_req = 1'b0; mem_ready = 1'b0;
      smp();
      chk("p_done_en", {31'd0, mem_en}, 32'd0);

      // Both requesters held: grants alternate D, I, D, I, ...
      nxt(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4000; d_wdata = 32'hAA; d_size = 3'b010;
      if_req = 1'b1; if_addr = 32'h400; mem_ready = 1'b1;
      smp();
      for (int k = 0; k < 6; k++) begin
         nxt();
         mem_rdata = 32'hA000_0000 + 32'(k);
         if (k == 5) d_req = 1'b0;
         push(k % 2 == 0, 32'hA000_0000 + 32'(k));
         smp();
         chk("alt_we", {31'd0, mem_we}, {31'd0, k % 2 == 0});
         chk("alt_addr", mem_addr, (k % 2 == 0) ? 32'h4000 : 32'h400);
      end
      nxt(); if_req = 1'b0; mem_ready = 1'b0;
      smp();
      chk("alt_end_en", {31'd0, mem_en}, 32'd0);

      // Load with mem_ready held low until forced completion.
      nxt(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
      smp();
      nxt(); push(1'b1, 32'h0000_0013);
      for (int c = 1; c <= 64; c++) begin
         if (c > 1) nxt();
         smp();
         chk("to_d_valid", {31'd0, d_valid}, {31'd0, c == 64});
         chk("to_err_pre", {31'd0, err_timeout}, 32'd0);
      end
      nxt(); d_req = 1'b0;
      smp();
      chk("to_en_after", {31'd0, mem_en}, 32'd0);
      chk("to_err_set", {31'd0, err_timeout}, 32'd1);
      nxt(); if_req = 1'b1; if_addr = 32'h800; mem_ready = 1'b1; mem_rdata = 32'h77;
      smp();
      nxt(); push(1'b0, 32'h77);
      smp();
      chk("to_good_valid", {31'd0, if_valid}, 32'd1);
      chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);
      nxt(); if_req = 1'b0; mem_ready = 1'b0;
      smp();
      chk("to_err_sticky2", {31'd0, err_timeout}, 32'd1);

      // Reset during the third cycle of a store.
      nxt(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h600; d_wdata = 32'h99;
      nxt(); nxt(); nxt(); reset = 1'b1;
      smp();
      chk("r_c3_en", {31'd0, mem_en}, 32'd1);
      chk("r_c3_valid", {31'd0, d_valid}, 32'd0);
      nxt(); reset = 1'b0; d_req = 1'b0;
      smp();
      chk("r_en", {31'd0, mem_en}, 32'd0);
      chk("r_we", {31'd0, mem_we}, 32'd0);
      chk("r_valid", {31'd0, d_valid}, 32'd0);
      chk("r_err", {31'd0, err_timeout}, 32'd0);

      nxt(); nxt();
      smp();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
